// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the two-port memory-bus arbiter.
// Holds FSM/port enums, counter width and the ROM/RAM region decode.
package mem_arbiter_pkg;

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    PORT_CPU,
    PORT_DMA
  } port_t;

  // Unsigned compare: everything at or above base is RAM.
  function automatic logic is_ram(logic [15:0] addr, logic [15:0] base);
    return addr >= base;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the requesters/memory side and the arbiter.
// master = CPU, DMA and ROM/RAM mux; slave = the arbiter itself.
interface mem_arbiter_if;

  logic        CPU_REQ;
  logic        CPU_WE;
  logic [15:0] CPU_ADDR;
  logic [7:0]  CPU_WDATA;
  logic [7:0]  CPU_RDATA;
  logic        CPU_ACK;

  logic        DMA_REQ;
  logic        DMA_WE;
  logic [15:0] DMA_ADDR;
  logic [7:0]  DMA_WDATA;
  logic [7:0]  DMA_RDATA;
  logic        DMA_ACK;

  logic [15:0] MEM_ADDR;
  logic [7:0]  MEM_WDATA;
  logic [7:0]  MEM_RDATA;
  logic        ROM_OE;
  logic        RAM_OE;
  logic        RAM_WE;
  logic        WERR;

  modport master (
    output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    input  CPU_RDATA, CPU_ACK,
    output DMA_REQ, DMA_WE, DMA_ADDR, DMA_WDATA,
    input  DMA_RDATA, DMA_ACK,
    input  MEM_ADDR, MEM_WDATA, ROM_OE, RAM_OE, RAM_WE, WERR,
    output MEM_RDATA
  );

  modport slave (
    input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    output CPU_RDATA, CPU_ACK,
    input  DMA_REQ, DMA_WE, DMA_ADDR, DMA_WDATA,
    output DMA_RDATA, DMA_ACK,
    output MEM_ADDR, MEM_WDATA, ROM_OE, RAM_OE, RAM_WE, WERR,
    input  MEM_RDATA
  );

endinterface

// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin grant. last_grant_q starts at DMA so the
// CPU wins the first tie; it is updated only when upd_i is strobed.
module mem_rr_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  req_cpu_i,
  input  logic  req_dma_i,
  input  logic  upd_i,
  input  port_t upd_port_i,
  output logic  gnt_valid_o,
  output port_t gnt_port_o
);

  port_t last_grant_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant_q <= PORT_DMA;
    end else if (upd_i) begin
      last_grant_q <= upd_port_i;
    end
  end

  always_comb begin
    gnt_valid_o = req_cpu_i | req_dma_i;
    gnt_port_o  = PORT_CPU;
    if (req_cpu_i && req_dma_i) begin
      gnt_port_o = (last_grant_q == PORT_CPU) ? PORT_DMA : PORT_CPU;
    end else if (req_dma_i) begin
      gnt_port_o = PORT_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 16-bit address / 8-bit data memory bus between CPU and DMA,
// with round-robin grant and counted per-region wait states.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ROM_WAIT = 9,
  parameter int unsigned RAM_WAIT = 1,
  parameter logic [15:0] RAM_BASE = 16'h8000
) (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave bus
);

  state_t            state_q;
  port_t             port_q;
  logic              we_q;
  logic [15:0]       addr_q;
  logic [7:0]        wdata_q;
  logic [CntW-1:0]   cnt_q;
  logic [7:0]        cpu_rdata_q, dma_rdata_q;
  logic              cpu_ack_q, dma_ack_q, werr_q;
  logic              rom_oe_q, ram_oe_q, ram_we_q;

  logic              gnt_valid;
  port_t             gnt_port;
  logic              gnt_we;
  logic [15:0]       gnt_addr;
  logic [7:0]        gnt_wdata;
  logic              gnt_ram;

  mem_rr_arbiter u_rr (
    .CLK        (CLK),
    .RST        (RST),
    .req_cpu_i  (bus.CPU_REQ),
    .req_dma_i  (bus.DMA_REQ),
    .upd_i      (state_q == DONE),
    .upd_port_i (port_q),
    .gnt_valid_o(gnt_valid),
    .gnt_port_o (gnt_port)
  );

  always_comb begin
    gnt_we    = (gnt_port == PORT_CPU) ? bus.CPU_WE    : bus.DMA_WE;
    gnt_addr  = (gnt_port == PORT_CPU) ? bus.CPU_ADDR  : bus.DMA_ADDR;
    gnt_wdata = (gnt_port == PORT_CPU) ? bus.CPU_WDATA : bus.DMA_WDATA;
    gnt_ram   = is_ram(gnt_addr, RAM_BASE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      port_q      <= PORT_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      werr_q      <= 1'b0;
      rom_oe_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      ram_we_q    <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      werr_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            port_q   <= gnt_port;
            we_q     <= gnt_we;
            addr_q   <= gnt_addr;
            wdata_q  <= gnt_wdata;
            cnt_q    <= gnt_ram ? CntW'(RAM_WAIT) : CntW'(ROM_WAIT);
            rom_oe_q <= !gnt_ram && !gnt_we;
            ram_oe_q <= gnt_ram && !gnt_we;
            ram_we_q <= gnt_ram && gnt_we;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            if (!we_q) begin
              if (port_q == PORT_CPU) cpu_rdata_q <= bus.MEM_RDATA;
              else                    dma_rdata_q <= bus.MEM_RDATA;
            end
            cpu_ack_q <= (port_q == PORT_CPU);
            dma_ack_q <= (port_q == PORT_DMA);
            // ROM writes complete normally but are flagged.
            werr_q    <= we_q && !is_ram(addr_q, RAM_BASE);
            rom_oe_q  <= 1'b0;
            ram_oe_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.MEM_ADDR  = addr_q;
  assign bus.MEM_WDATA = wdata_q;
  assign bus.ROM_OE    = rom_oe_q;
  assign bus.RAM_OE    = ram_oe_q;
  assign bus.RAM_WE    = ram_we_q;
  assign bus.WERR      = werr_q;
  assign bus.CPU_RDATA = cpu_rdata_q;
  assign bus.DMA_RDATA = dma_rdata_q;
  assign bus.CPU_ACK   = cpu_ack_q;
  assign bus.DMA_ACK   = dma_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: ROM/RAM latency, strobes, round-robin,
// ROM-write error and reset mid-access, all against hand-computed values.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .ROM_WAIT(9),
    .RAM_WAIT(1),
    .RAM_BASE(16'h8000)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs until an ACK shows (bounded); port: 0 none, 1 CPU, 2 DMA, 3 both.
  task automatic xfer(output int rom, output int ramoe, output int ramwe, output int port,
                      output int lat, output logic werr, output logic [15:0] addr,
                      output logic [7:0] wd);
    rom = 0; ramoe = 0; ramwe = 0; port = 0; lat = 0;
    werr = 1'b0; addr = '0; wd = '0;
    for (int i = 1; i <= 60 && port == 0; i++) begin
      tick();
      if (bus.ROM_OE) rom++;
      if (bus.RAM_OE) ramoe++;
      if (bus.RAM_WE) ramwe++;
      if (bus.ROM_OE || bus.RAM_OE || bus.RAM_WE) begin
        addr = bus.MEM_ADDR;
        wd   = bus.MEM_WDATA;
      end
      if (bus.CPU_ACK && bus.DMA_ACK) port = 3;
      else if (bus.CPU_ACK)           port = 1;
      else if (bus.DMA_ACK)           port = 2;
      if (port != 0) begin
        lat  = i;
        werr = bus.WERR;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, 32'(bus.MEM_ADDR), 32'h0);
    check({tag, "_data"}, 32'({bus.MEM_WDATA, bus.CPU_RDATA, bus.DMA_RDATA}), 32'h0);
    check({tag, "_ctl"}, 32'({bus.ROM_OE, bus.RAM_OE, bus.RAM_WE, bus.CPU_ACK, bus.DMA_ACK,
                              bus.WERR}), 32'h0);
  endtask

  int rom, ramoe, ramwe, port, lat;
  logic werr;
  logic [15:0] addr;
  logic [7:0] wd;

  initial begin
    bus.CPU_REQ = 0; bus.CPU_WE = 0; bus.CPU_ADDR = 0; bus.CPU_WDATA = 0;
    bus.DMA_REQ = 0; bus.DMA_WE = 0; bus.DMA_ADDR = 0; bus.DMA_WDATA = 0;
    bus.MEM_RDATA = 8'hA5;
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // CPU ROM read: 10 strobe cycles, ACK at request+11.
    bus.CPU_REQ = 1; bus.CPU_WE = 0; bus.CPU_ADDR = 16'h0010;
    xfer(rom, ramoe, ramwe, port, lat, werr, addr, wd);
    bus.CPU_REQ = 0;
    check("rd_rom_oe_cycles", 32'(rom), 32'd10);
    check("rd_other_strobes", 32'(ramoe + ramwe), 32'd0);
    check("rd_ack_port", 32'(port), 32'd1);
    check("rd_latency", 32'(lat), 32'd11);
    check("rd_mem_addr", 32'(addr), 32'h0010);
    check("rd_cpu_rdata", 32'(bus.CPU_RDATA), 32'hA5);
    check("rd_dma_rdata", 32'(bus.DMA_RDATA), 32'h00);
    tick();
    check("rd_ack_one_cycle", 32'(bus.CPU_ACK), 32'd0);

    // DMA RAM write: 2 RAM_WE cycles, no WERR.
    bus.MEM_RDATA = 8'hEE;
    bus.DMA_REQ = 1; bus.DMA_WE = 1; bus.DMA_ADDR = 16'h8004; bus.DMA_WDATA = 8'h3C;
    xfer(rom, ramoe, ramwe, port, lat, werr, addr, wd);
    bus.DMA_REQ = 0;
    check("wr_ram_we_cycles", 32'(ramwe), 32'd2);
    check("wr_other_strobes", 32'(rom + ramoe), 32'd0);
    check("wr_ack_port", 32'(port), 32'd2);
    check("wr_latency", 32'(lat), 32'd3);
    check("wr_mem_addr", 32'(addr), 32'h8004);
    check("wr_mem_wdata", 32'(wd), 32'h3C);
    check("wr_werr", 32'(werr), 32'd0);
    check("wr_rdata_kept", 32'({bus.CPU_RDATA, bus.DMA_RDATA}), 32'hA500);
    tick();

    // Fresh reset, then both ports held high: CPU, DMA, CPU, DMA.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.MEM_RDATA = 8'h5A;
    bus.CPU_REQ = 1; bus.CPU_WE = 0; bus.CPU_ADDR = 16'h0020;
    bus.DMA_REQ = 1; bus.DMA_WE = 0; bus.DMA_ADDR = 16'h8010;
    for (int k = 0; k < 4; k++) begin
      xfer(rom, ramoe, ramwe, port, lat, werr, addr, wd);
      check($sformatf("rr_grant%0d", k), 32'(port), (k % 2 == 0) ? 32'd1 : 32'd2);
    end
    bus.CPU_REQ = 0; bus.DMA_REQ = 0;
    check("rr_dma_rdata", 32'(bus.DMA_RDATA), 32'h5A);
    tick();

    // CPU write just below RAM_BASE: no strobe, ACK with WERR.
    bus.CPU_REQ = 1; bus.CPU_WE = 1; bus.CPU_ADDR = 16'h7FFF; bus.CPU_WDATA = 8'h55;
    xfer(rom, ramoe, ramwe, port, lat, werr, addr, wd);
    check("romwr_strobes", 32'(rom + ramoe + ramwe), 32'd0);
    check("romwr_ack_port", 32'(port), 32'd1);
    check("romwr_werr", 32'(werr), 32'd1);
    check("romwr_latency", 32'(lat), 32'd11);
    // Immediate write at RAM_BASE, REQ kept high through the ACK.
    bus.CPU_ADDR = 16'h8000; bus.CPU_WDATA = 8'h77;
    xfer(rom, ramoe, ramwe, port, lat, werr, addr, wd);
    bus.CPU_REQ = 0;
    check("base_ram_we_cycles", 32'(ramwe), 32'd2);
    check("base_mem_addr", 32'(addr), 32'h8000);
    check("base_werr", 32'(werr), 32'd0);
    check("base_latency", 32'(lat), 32'd4);
    tick();

    // Reset during the 3rd ACCESS cycle of a ROM read.
    bus.CPU_REQ = 1; bus.CPU_WE = 0; bus.CPU_ADDR = 16'h0030;
    tick();
    tick();
    tick();
    check("abort_rom_oe_before", 32'(bus.ROM_OE), 32'd1);
    rst = 1'b1;
    bus.CPU_REQ = 0;
    tick();
    check_all_zero("abort");
    rst = 1'b0;
    tick();
    check("abort_no_late_ack", 32'({bus.CPU_ACK, bus.ROM_OE}), 32'd0);
    // last_grant was CPU before reset; reset returns it to DMA so CPU wins.
    bus.CPU_REQ = 1; bus.CPU_WE = 0; bus.CPU_ADDR = 16'h0040;
    bus.DMA_REQ = 1; bus.DMA_WE = 0; bus.DMA_ADDR = 16'h8020;
    xfer(rom, ramoe, ramwe, port, lat, werr, addr, wd);
    bus.CPU_REQ = 0; bus.DMA_REQ = 0;
    check("post_reset_tie", 32'(port), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
